// File: rtl/type_package.sv
// Shared types for the PU memory port arbiter.
// Fallback values stand in for defines.vh in standalone builds.
`ifndef PIO_RANGE
`define PIO_RANGE 31:0
`endif
`ifndef PU_WIDTH_NBITS
`define PU_WIDTH_NBITS 16
`endif
`ifndef SWITCH_INFO_DEPTH_NBITS
`define SWITCH_INFO_DEPTH_NBITS 8
`endif
`ifndef NUM_OF_PU
`define NUM_OF_PU 4
`endif

package type_package;

    localparam int MAX_STARVE_DEF = 8;

    typedef struct packed {
        logic vld;
        logic is_pio;
        logic is_wr;
    } arb_tag_t;

    typedef enum logic [1:0] {
        PIO_IDLE = 2'd0,
        PIO_PEND = 2'd1,
        PIO_WAIT = 2'd2
    } pio_st_e;

endpackage

// File: rtl/sfifo2f_fo.sv
// Two-entry first-word-fall-through FIFO.
// A push while full is taken only if a pop frees the slot.
module sfifo2f_fo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [2];
    logic             wp;
    logic             rp;
    logic [1:0]       cnt;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & (cnt != 2'd0);
    assign do_push = push & ((cnt != 2'd2) | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wp] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wp  <= 1'b0;
            rp  <= 1'b0;
            cnt <= 2'd0;
        end else begin
            if (do_push) begin
                wp <= ~wp;
            end
            if (do_pop) begin
                rp <= ~rp;
            end
            cnt <= cnt + 2'(do_push) - 2'(do_pop);
        end
    end

    assign dout  = mem[rp];
    assign empty = (cnt == 2'd0);
    assign full  = (cnt == 2'd2);

endmodule

// File: rtl/pu_mem_port_arb.sv
// Single-port BRAM sharing between PIO and PU app reads, app favoured.
// PU_MEM_PORT_ARB_STARVE_EN enables the PIO starvation guard.
module pu_mem_port_arb
    import type_package::*;
#(
    parameter int NUM_OF_PU   = `NUM_OF_PU,
    parameter int WIDTH_NBITS = `PU_WIDTH_NBITS,
    parameter int DEPTH_NBITS = `SWITCH_INFO_DEPTH_NBITS,
    parameter int RD_LAT      = 2,
    parameter int MAX_STARVE  = MAX_STARVE_DEF
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [`PIO_RANGE]      reg_addr,
    input  logic [`PIO_RANGE]      reg_din,
    input  logic                   reg_rd,
    input  logic                   reg_wr,
    input  logic                   reg_ms,
    output logic                   mem_ack,
    output logic [`PIO_RANGE]      mem_rdata,
    input  logic                   app_mem_rd,
    input  logic [DEPTH_NBITS-1:0] app_mem_raddr,
    output logic                   app_mem_busy,
    output logic                   app_mem_ack,
    output logic [WIDTH_NBITS-1:0] app_mem_rdata,
    output logic                   ram_en,
    output logic                   ram_we,
    output logic [DEPTH_NBITS-1:0] ram_addr,
    output logic [WIDTH_NBITS-1:0] ram_wdata,
    input  logic [WIDTH_NBITS-1:0] ram_rdata
);

    localparam int PIO_NBITS = $bits(reg_addr);

    pio_st_e                st;
    pio_st_e                st_nxt;
    logic [DEPTH_NBITS-1:0] pio_addr;
    logic [WIDTH_NBITS-1:0] pio_wdata;
    logic                   pio_wr;
    logic                   pio_strobe;
    logic                   pio_req;
    logic                   pio_force;
    logic                   gnt_app;
    logic                   gnt_pio;
    logic                   q_empty;
    logic                   q_full;
    logic [DEPTH_NBITS-1:0] q_addr;
    arb_tag_t               pipe [RD_LAT];
    arb_tag_t               tag_in;
    arb_tag_t               tag_out;
    logic                   pio_done;
    logic                   app_done;
    logic                   unused_ok;

    assign pio_strobe = reg_ms & (reg_rd | reg_wr);

    sfifo2f_fo #(
        .WIDTH (DEPTH_NBITS)
    ) u_app_q (
        .clk   (clk),
        .rstn  (rstn),
        .push  (app_mem_rd & ~q_full),
        .pop   (gnt_app),
        .din   (app_mem_raddr),
        .dout  (q_addr),
        .empty (q_empty),
        .full  (q_full)
    );

    assign app_mem_busy = q_full;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            st <= PIO_IDLE;
        end else begin
            st <= st_nxt;
        end
    end

    always_comb begin
        st_nxt = st;
        unique case (st)
            PIO_IDLE: if (pio_strobe) st_nxt = PIO_PEND;
            PIO_PEND: if (gnt_pio)    st_nxt = PIO_WAIT;
            PIO_WAIT: if (pio_done)   st_nxt = PIO_IDLE;
            default:                  st_nxt = PIO_IDLE;
        endcase
    end

    always_comb begin
        pio_req = (st == PIO_PEND);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pio_addr  <= '0;
            pio_wdata <= '0;
            pio_wr    <= 1'b0;
        end else if (st == PIO_IDLE && pio_strobe) begin
            pio_addr  <= reg_addr[DEPTH_NBITS-1:0];
            pio_wdata <= reg_din[WIDTH_NBITS-1:0];
            pio_wr    <= reg_wr;
        end
    end

`ifdef PU_MEM_PORT_ARB_STARVE_EN
    localparam int SW = $clog2(MAX_STARVE + 1);

    logic [SW-1:0] starve;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            starve <= '0;
        end else if (gnt_pio) begin
            starve <= '0;
        end else if (pio_req && starve != SW'(MAX_STARVE)) begin
            starve <= starve + SW'(1);
        end
    end

    assign pio_force = pio_req & (starve == SW'(MAX_STARVE));
`else
    assign pio_force = 1'b0;
`endif

    // Grants are held off during reset so no stray write hits the RAM.
    always_comb begin
        gnt_app = rstn & ~q_empty & ~pio_force;
        gnt_pio = rstn & pio_req & ~gnt_app;
    end

    always_comb begin
        ram_en    = gnt_app | gnt_pio;
        ram_we    = gnt_pio & pio_wr;
        ram_addr  = '0;
        ram_wdata = '0;
        if (gnt_pio) begin
            ram_addr = pio_addr;
            if (pio_wr) begin
                ram_wdata = pio_wdata;
            end
        end else if (gnt_app) begin
            ram_addr = q_addr;
        end
    end

    always_comb begin
        tag_in = '{vld: ram_en, is_pio: gnt_pio, is_wr: ram_we};
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= tag_in;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Exit stage lines up with the RAM output register.
    assign tag_out  = pipe[RD_LAT-1];
    assign pio_done = tag_out.vld & tag_out.is_pio;
    assign app_done = tag_out.vld & ~tag_out.is_pio;

    always_comb begin
        mem_ack       = pio_done;
        app_mem_ack   = app_done;
        mem_rdata     = '0;
        app_mem_rdata = '0;
        if (pio_done && !tag_out.is_wr) begin
            mem_rdata[WIDTH_NBITS-1:0] = ram_rdata;
        end
        if (app_done) begin
            app_mem_rdata = ram_rdata;
        end
    end

    assign unused_ok = &{1'b0,
                         reg_addr[PIO_NBITS-1:DEPTH_NBITS],
                         reg_din[PIO_NBITS-1:WIDTH_NBITS],
                         NUM_OF_PU[0],
                         MAX_STARVE[0]};

endmodule
